// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared encodings and helpers for the memory port arbiter
package mem_arb_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_ACCESS = 2'd1;
    localparam state_t ST_DONE   = 2'd2;

    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;

    localparam int LAT_W = 4;
    localparam logic [31:0] CNT_MAX = 32'hFFFFFFFF;

    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == CNT_MAX) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/mem_arb_lat_counter.sv
// rtl/mem_arb_lat_counter.sv - loadable down-counter timing one memory access
module mem_arb_lat_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing one memory between I-fetch and data ports
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int LATENCY = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              i_req_i,
    input  logic [ADDR_W-1:0] i_addr_i,
    output logic              i_ack_o,
    output logic [DATA_W-1:0] i_rdata_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic              d_ack_o,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [31:0]       i_cnt_o,
    output logic [31:0]       d_cnt_o
);

    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(LATENCY - 1);

    state_t            state;
    logic              gnt;
    logic              last_gnt;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] i_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic [31:0]       i_cnt_q;
    logic [31:0]       d_cnt_q;

    logic any_req;
    logic pick_d;
    logic lat_load;
    logic lat_dec;
    logic lat_zero;

    // D wins when alone, or on contention when I held the previous grant.
    always_comb begin
        any_req  = i_req_i | d_req_i;
        pick_d   = d_req_i & (~i_req_i | (last_gnt == GNT_I));
        lat_load = (state == ST_IDLE) & any_req;
        lat_dec  = (state == ST_ACCESS);
    end

    mem_arb_lat_counter #(
        .W(LAT_W)
    ) u_lat (
        .clk      (clk_i),
        .rst      (rst_i),
        .load     (lat_load),
        .load_val (LAT_INIT),
        .dec      (lat_dec),
        .zero     (lat_zero)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= ST_IDLE;
            gnt       <= GNT_I;
            last_gnt  <= GNT_I;
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            i_cnt_q   <= '0;
            d_cnt_q   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        gnt      <= pick_d ? GNT_D : GNT_I;
                        last_gnt <= pick_d ? GNT_D : GNT_I;
                        addr_q   <= pick_d ? d_addr_i : i_addr_i;
                        we_q     <= pick_d & d_we_i;
                        wdata_q  <= d_wdata_i;
                        state    <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (lat_zero) begin
                        if (gnt == GNT_D) begin
                            d_rdata_q <= mem_rdata_i;
                            d_cnt_q   <= sat_inc(d_cnt_q);
                        end else begin
                            i_rdata_q <= mem_rdata_i;
                            i_cnt_q   <= sat_inc(i_cnt_q);
                        end
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_req_o   = (state == ST_ACCESS);
    assign mem_we_o    = mem_req_o & we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign i_ack_o     = (state == ST_DONE) & (gnt == GNT_I);
    assign d_ack_o     = (state == ST_DONE) & (gnt == GNT_D);
    assign i_rdata_o   = i_rdata_q;
    assign d_rdata_o   = d_rdata_q;
    assign i_cnt_o     = i_cnt_q;
    assign d_cnt_o     = d_cnt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter at LATENCY 4 and 1
module tb_mem_port_arbiter;

    localparam logic [31:0] K = 32'h8C010014;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;

    logic        i_ack [2];
    logic        d_ack [2];
    logic        mem_req [2];
    logic        mem_we [2];
    logic [31:0] i_rdata [2];
    logic [31:0] d_rdata [2];
    logic [31:0] mem_addr [2];
    logic [31:0] mem_wdata [2];
    logic [31:0] mem_rdata [2];
    logic [31:0] i_cnt [2];
    logic [31:0] d_cnt [2];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int base = 0;

    task automatic chk(input string name, input int lane, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s lane%0d actual=%h expected=%h", name, lane, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    generate
        for (genvar g = 0; g < 2; g++) begin : lane
            localparam int L = (g == 0) ? 4 : 1;

            assign mem_rdata[g] = mem_addr[g] ^ K;

            mem_port_arbiter #(
                .ADDR_W  (32),
                .DATA_W  (32),
                .LATENCY (L)
            ) dut (
                .clk_i       (clk),
                .rst_i       (rst),
                .i_req_i     (i_req),
                .i_addr_i    (i_addr),
                .i_ack_o     (i_ack[g]),
                .i_rdata_o   (i_rdata[g]),
                .d_req_i     (d_req),
                .d_we_i      (d_we),
                .d_addr_i    (d_addr),
                .d_wdata_i   (d_wdata),
                .d_ack_o     (d_ack[g]),
                .d_rdata_o   (d_rdata[g]),
                .mem_req_o   (mem_req[g]),
                .mem_we_o    (mem_we[g]),
                .mem_addr_o  (mem_addr[g]),
                .mem_wdata_o (mem_wdata[g]),
                .mem_rdata_i (mem_rdata[g]),
                .i_cnt_o     (i_cnt[g]),
                .d_cnt_o     (d_cnt[g])
            );

            // Transaction timeline: grant at phase 0, memory busy phases 1..L, ack at L+1.
            bit          busy, port, last, l_we, e_req;
            int          ph;
            logic [31:0] l_addr, l_wdata, m_addr, m_wdata, e_ird, e_drd, e_icnt, e_dcnt;

            initial begin
                busy = 0; ph = 0; last = 0; port = 0; l_we = 0;
                l_addr = 0; l_wdata = 0; m_addr = 0; m_wdata = 0;
                e_ird = 0; e_drd = 0; e_icnt = 0; e_dcnt = 0;
                forever begin
                    @(negedge clk);
                    if (rst) begin
                        busy = 0; ph = 0; last = 0; l_we = 0;
                        m_addr = 0; m_wdata = 0;
                        e_ird = 0; e_drd = 0; e_icnt = 0; e_dcnt = 0;
                    end else begin
                        if (busy) ph++;
                        if (busy && ph == 1) begin
                            m_addr  = l_addr;
                            m_wdata = l_wdata;
                        end
                        if (busy && ph == L + 1) begin
                            if (port) begin
                                e_drd = l_addr ^ K;
                                if (e_dcnt != 32'hFFFFFFFF) e_dcnt++;
                            end else begin
                                e_ird = l_addr ^ K;
                                if (e_icnt != 32'hFFFFFFFF) e_icnt++;
                            end
                        end
                    end
                    e_req = busy && ph >= 1 && ph <= L;
                    chk("mem_req",   g, 32'(mem_req[g]), 32'(e_req));
                    chk("mem_we",    g, 32'(mem_we[g]),  32'(e_req && l_we));
                    chk("mem_addr",  g, mem_addr[g],     m_addr);
                    chk("mem_wdata", g, mem_wdata[g],    m_wdata);
                    chk("i_ack",     g, 32'(i_ack[g]),   32'(busy && ph == L + 1 && !port));
                    chk("d_ack",     g, 32'(d_ack[g]),   32'(busy && ph == L + 1 && port));
                    chk("i_rdata",   g, i_rdata[g],      e_ird);
                    chk("d_rdata",   g, d_rdata[g],      e_drd);
                    chk("i_cnt",     g, i_cnt[g],        e_icnt);
                    chk("d_cnt",     g, d_cnt[g],        e_dcnt);
                    if (!rst) begin
                        if (busy && ph == L + 1) begin
                            busy = 0;
                        end else if (!busy && (i_req || d_req)) begin
                            port    = d_req && (!i_req || !last);
                            last    = port;
                            l_addr  = port ? d_addr : i_addr;
                            l_we    = port && d_we;
                            l_wdata = d_wdata;
                            busy    = 1;
                            ph      = 0;
                        end
                    end
                end
            end
        end
    endgenerate

    task automatic do_reset();
        rst = 1'b1;
        i_req = 0; d_req = 0; d_we = 0;
        i_addr = 0; d_addr = 0; d_wdata = 0;
        repeat (2) @(posedge clk);
        #2;
        rst  = 1'b0;
        base = cyc;
    endtask

    // Returns the ack cycle relative to reset release, or -1 on timeout.
    task automatic wait_ack(input int ln, input int max, output int n, output int port,
                            output int mreqs, output int wes);
        n = -1; port = -1; mreqs = 0; wes = 0;
        for (int k = 0; k < max; k++) begin
            @(negedge clk);
            if (mem_req[ln]) mreqs++;
            if (mem_we[ln] && mem_wdata[ln] == 32'hDEADBEEF) wes++;
            if (i_ack[ln] || d_ack[ln]) begin
                n    = cyc - base;
                port = d_ack[ln] ? 1 : 0;
                return;
            end
        end
    endtask

    int n, p, mr, we;

    initial begin
        i_req = 0; d_req = 0; d_we = 0;
        i_addr = 0; d_addr = 0; d_wdata = 0;

        @(negedge clk);
        chk("rst_mem_req", 0, 32'(mem_req[0]), 32'd0);
        chk("rst_i_cnt",   0, i_cnt[0], 32'd0);

        // single I read
        do_reset();
        i_req = 1; i_addr = 32'h10;
        wait_ack(0, 30, n, p, mr, we);
        chk("t1_ack_cycle", 0, n, 32'd5);
        chk("t1_port",      0, p, 32'd0);
        chk("t1_mreq_cyc",  0, mr, 32'd4);
        chk("t1_rdata",     0, i_rdata[0], 32'h8C010004);
        chk("t1_icnt",      0, i_cnt[0], 32'd1);
        chk("t1_addr",      0, mem_addr[0], 32'h10);

        // single D write
        do_reset();
        d_req = 1; d_we = 1; d_addr = 32'h20; d_wdata = 32'hDEADBEEF;
        wait_ack(0, 30, n, p, mr, we);
        chk("t2_ack_cycle", 0, n, 32'd5);
        chk("t2_port",      0, p, 32'd1);
        chk("t2_we_cyc",    0, we, 32'd4);
        chk("t2_dcnt",      0, d_cnt[0], 32'd1);
        chk("t2_icnt",      0, i_cnt[0], 32'd0);

        // continuous contention alternates D, I, D, I
        do_reset();
        i_req = 1; d_req = 1; i_addr = 32'h100; d_addr = 32'h200;
        for (int k = 0; k < 4; k++) begin
            wait_ack(0, 30, n, p, mr, we);
            chk("t3_ack_cycle", 0, n, 32'(5 + 6 * k));
            chk("t3_port",      0, p, 32'(((k % 2) == 0) ? 1 : 0));
        end
        chk("t3_icnt", 0, i_cnt[0], 32'd2);
        chk("t3_dcnt", 0, d_cnt[0], 32'd2);

        // address change during ACCESS is ignored; I follows right after D
        do_reset();
        i_req = 1; d_req = 1; i_addr = 32'h44; d_addr = 32'h40;
        @(posedge clk); #2;
        @(posedge clk); #2;
        d_addr = 32'h99;
        @(negedge clk);
        chk("t4_addr_hold", 0, mem_addr[0], 32'h40);
        wait_ack(0, 30, n, p, mr, we);
        chk("t4_d_ack_cycle", 0, n, 32'd5);
        chk("t4_d_port",      0, p, 32'd1);
        chk("t4_d_rdata",     0, d_rdata[0], 32'h8C010054);
        wait_ack(0, 30, n, p, mr, we);
        chk("t4_i_ack_cycle", 0, n, 32'd11);
        chk("t4_i_port",      0, p, 32'd0);
        chk("t4_i_rdata",     0, i_rdata[0], 32'h8C010050);

        // reset during the 2nd ACCESS cycle of a D read
        do_reset();
        d_req = 1; d_we = 0; d_addr = 32'h30;
        @(posedge clk); #2;
        @(posedge clk); #2;
        rst = 1; d_req = 0;
        @(negedge clk);
        chk("t5_zero_ctl", 0, 32'({mem_req[0], mem_we[0], i_ack[0], d_ack[0]}), 32'd0);
        chk("t5_zero_dat", 0, mem_addr[0] | mem_wdata[0] | i_rdata[0] | d_rdata[0] | i_cnt[0] | d_cnt[0], 32'd0);
        @(posedge clk); #2;
        rst = 0; base = cyc;
        i_req = 1; i_addr = 32'h8;
        wait_ack(0, 30, n, p, mr, we);
        chk("t5_ack_cycle", 0, n, 32'd5);
        chk("t5_port",      0, p, 32'd0);
        chk("t5_rdata",     0, i_rdata[0], 32'h8C01001C);
        chk("t5_dcnt",      0, d_cnt[0], 32'd0);

        // LATENCY=1 back-to-back I reads
        do_reset();
        i_req = 1; i_addr = 32'h0;
        wait_ack(1, 30, n, p, mr, we);
        chk("t6_ack1_cycle", 1, n, 32'd2);
        chk("t6_mreq1",      1, mr, 32'd1);
        chk("t6_rdata1",     1, i_rdata[1], 32'h8C010014);
        @(posedge clk); #2;
        i_addr = 32'h4;
        wait_ack(1, 30, n, p, mr, we);
        chk("t6_ack2_cycle", 1, n, 32'd5);
        chk("t6_mreq2",      1, mr, 32'd1);
        chk("t6_rdata2",     1, i_rdata[1], 32'h8C010010);
        chk("t6_icnt",       1, i_cnt[1], 32'd2);

        i_req = 0; d_req = 0;
        repeat (8) @(posedge clk);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port backing memory between the CPU instruction-fetch requester (I, read-only) and the data requester (D, read/write).
- Sits between the CPU pipeline's fetch/MEM stages and the memory model.
- Each access holds the memory for a fixed LATENCY cycles and is closed by a one-cycle ack.
- Round-robin arbitration on contention; per-port completed-access counters for trace cross-checking.

Parameters:
ADDR_W, 32, address width, both ports and memory
DATA_W, 32, data width
LATENCY, 4, memory cycles per access; legal range 1..15

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-high
i_req_i  in  1  I-port request, level, held until i_ack_o
i_addr_i  in  ADDR_W  I-port address
i_ack_o  out  1  I access complete, one-cycle pulse
i_rdata_o  out  DATA_W  I read data, valid while i_ack_o
d_req_i  in  1  D-port request, level, held until d_ack_o
d_we_i  in  1  D write enable (1 write, 0 read)
d_addr_i  in  ADDR_W  D address
d_wdata_i  in  DATA_W  D write data
d_ack_o  out  1  D access complete, one-cycle pulse
d_rdata_o  out  DATA_W  D read data, valid while d_ack_o and read
mem_req_o  out  1  memory access active
mem_we_o  out  1  memory write strobe
mem_addr_o  out  ADDR_W  memory address
mem_wdata_o  out  DATA_W  memory write data
mem_rdata_i  in  DATA_W  memory read data, valid in last access cycle
i_cnt_o  out  32  completed I accesses, saturating
d_cnt_o  out  32  completed D accesses, saturating

Behaviour:
Reset:
- While rst_i is high, all outputs are 0, state is IDLE, and last_grant = I (so D wins the first contention).
- Reset asserted mid-access: the access is aborted, no ack is issued, and the counters are cleared.

States:
- IDLE: arbitrate.
  - Only d_req_i high: grant D.
  - Only i_req_i high: grant I.
  - Both high: grant the port opposite last_grant.
  - On grant: latch addr/we/wdata and the granted port, update last_grant, set lat_cnt = LATENCY-1, go to ACCESS.
  - No request: stay in IDLE.
- ACCESS:
  - mem_req_o = 1; mem_addr_o, mem_we_o and mem_wdata_o are driven from the latched values and are stable for all LATENCY cycles.
  - mem_we_o = 1 only for a D write (I grants always read).
  - lat_cnt decrements each cycle. When lat_cnt == 0, capture mem_rdata_i into the granted port's rdata register and go to DONE.
- DONE:
  - Granted port's ack = 1 for exactly one cycle; the other ack stays 0.
  - Granted port's counter increments (holds at 0xFFFFFFFF).
  - mem_req_o = 0. No arbitration this cycle. Next state is IDLE.

Timing:
- Request first seen in IDLE at cycle 0 → mem_req_o high in cycles 1..LATENCY → ack in cycle LATENCY+1.
- Minimum spacing between grants: LATENCY+2 cycles.
- Idle memory port: mem_req_o = 0, mem_we_o = 0, mem_addr_o and mem_wdata_o hold their last values.

Handshake and boundary rules:
- Port inputs are sampled only in IDLE. Changes to request inputs during ACCESS or DONE are ignored.
- A requester that drops its req mid-access still receives its ack.
- rdata_o holds its value after ack until the next completion on that port. For a D write, d_rdata_o is updated with mem_rdata_i (don't-care to the requester).
- i_ack_o and d_ack_o are never high in the same cycle.
- LATENCY = 1: exactly one ACCESS cycle.

Decomposition:
- Package mem_arb_pkg:
  - state encoding: IDLE=2'd0, ACCESS=2'd1, DONE=2'd2
  - grant encoding: GNT_I=1'b0, GNT_D=1'b1
  - LAT_W = 4 (counter width)
  - CNT_MAX = 32'hFFFFFFFF
- One natural sub-module: mem_arb_lat_counter, a loadable down-counter with a zero flag, driving the ACCESS→DONE transition.
- The arbiter FSM and the saturating access counters stay in the top module.

Test Plan:
1. Reset, then i_req_i=1, i_addr_i=0x00000010, mem_rdata_i=0x8C010004, LATENCY=4:
   - mem_req_o high cycles 1-4 with mem_addr_o=0x10, mem_we_o=0.
   - i_ack_o pulses in cycle 5 with i_rdata_o=0x8C010004; i_cnt_o=1.
2. d_req_i=1, d_we_i=1, d_addr_i=0x20, d_wdata_i=0xDEADBEEF:
   - mem_we_o=1 and mem_wdata_o=0xDEADBEEF for 4 cycles.
   - d_ack_o single pulse; d_cnt_o=1; i_ack_o stays 0.
3. i_req_i and d_req_i both held high continuously from reset:
   - Grants alternate D, I, D, I.
   - Acks spaced 6 cycles apart; after 4 acks, i_cnt_o=2 and d_cnt_o=2.
4. Both requests high, then d_addr_i changed during ACCESS:
   - mem_addr_o stays at the originally latched value.
   - I request waits and is granted in the IDLE cycle after d_ack_o.
5. rst_i asserted in the 2nd ACCESS cycle of a D read:
   - All outputs 0 immediately; no d_ack_o is issued.
   - After release, a fresh i_req_i is granted normally.
6. LATENCY=1 build, back-to-back I reads of 0x0 then 0x4:
   - Acks in cycles 2 and 5.
   - mem_req_o high in exactly cycles 1 and 4.
